// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM state encoding, default operand width and mode encodings for the RSA job sequencer.
package rsa_pkg;
  localparam int RSA_WIDTH = 256;
  localparam logic ENCRYPT = 1'b1;
  localparam logic DECRYPT = 1'b0;
  typedef enum logic [2:0] {IDLE, RST, KEYGEN, START, RUN, RESP} state_t;
endpackage

// File: rtl/rsa_seq_counter.sv
// rsa_seq_counter: clearable saturating up-counter; tc flags the LIMIT-th counted cycle.
module rsa_seq_counter #(
  parameter int LIMIT = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(LIMIT) + 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= clr ? '0 : (en && cnt != CW'(LIMIT)) ? cnt + 1'b1 : cnt;
  assign tc = cnt >= CW'(LIMIT - 1);
endmodule

// File: rtl/rsa_job_sequencer.sv
// rsa_job_sequencer: sequences one RSA job through the control core (reset, keygen wait, start, run, respond).
// Optional RUN timeout abort is enabled by defining RSA_SEQ_TIMEOUT_EN.
module rsa_job_sequencer
  import rsa_pkg::*;
#(
  parameter int WIDTH          = RSA_WIDTH,
  parameter int KEYGEN_WAIT    = 100,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_p,
  input  logic [WIDTH-1:0] req_q,
  input  logic [WIDTH-1:0] req_msg,
  input  logic             req_mode,
  output logic [WIDTH-1:0] core_p,
  output logic [WIDTH-1:0] core_q,
  output logic [WIDTH-1:0] core_msg_in,
  output logic             core_encrypt_decrypt,
  output logic             core_reset,
  output logic             core_reset1,
  input  logic [WIDTH-1:0] core_msg_out,
  input  logic             core_finish,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_msg,
  output logic             rsp_timeout
);
  state_t state;
  logic   fin_low;
  logic   kg_tc;
  rsa_seq_counter #(.LIMIT(KEYGEN_WAIT)) u_kg (
    .clk(clk), .reset(reset), .clr(state == RST), .en(state == KEYGEN), .tc(kg_tc)
  );
`ifdef RSA_SEQ_TIMEOUT_EN
  logic run_tc;
  rsa_seq_counter #(.LIMIT(TIMEOUT_CYCLES)) u_run (
    .clk(clk), .reset(reset), .clr(state == START), .en(state == RUN), .tc(run_tc)
  );
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign rsp_timeout = 1'b0;
`endif
  // fin_low records a low core_finish sample in RUN, so a level already high on entry never counts as done
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state                <= IDLE;
      req_ready            <= 1'b1;
      core_p               <= '0;
      core_q               <= '0;
      core_msg_in          <= '0;
      core_encrypt_decrypt <= 1'b0;
      core_reset           <= 1'b0;
      core_reset1          <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_msg              <= '0;
      fin_low              <= 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
      rsp_timeout          <= 1'b0;
`endif
    end else
      case (state)
        IDLE:
          if (req_valid && req_ready) begin
            core_p               <= req_p;
            core_q               <= req_q;
            core_msg_in          <= req_msg;
            core_encrypt_decrypt <= req_mode;
            req_ready            <= 1'b0;
            core_reset           <= 1'b1;
            state                <= RST;
          end
        RST: begin
          core_reset <= 1'b0;
          state      <= KEYGEN;
        end
        KEYGEN:
          if (kg_tc) begin
            core_reset1 <= 1'b1;
            state       <= START;
          end
        START: begin
          core_reset1 <= 1'b0;
          fin_low     <= 1'b0;
          state       <= RUN;
        end
        RUN: begin
          if (!core_finish) fin_low <= 1'b1;
          if (fin_low && core_finish) begin
            rsp_msg   <= core_msg_out;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef RSA_SEQ_TIMEOUT_EN
            rsp_timeout <= 1'b0;
          end else if (run_tc) begin
            rsp_msg     <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
`endif
          end
        end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb_rsa_job_sequencer: directed self-checking bench for rsa_job_sequencer with a hand-driven core model.
module tb_rsa_job_sequencer;
  localparam int W  = 256;
  localparam int KW = 100;
  localparam logic [W-1:0] P  = 256'd113680897410347;
  localparam logic [W-1:0] Q  = 256'd7999808077935876437321;
  localparam logic [W-1:0] M1 = 256'h48656c6c6f20576f726c6421;
  localparam logic [W-1:0] M3 = 256'h262d806a3e18f03ab37b2857e7e149;
  localparam logic [W-1:0] R1 = 256'hdeadbeef_0badf00d_12345678_9abcdef0;
  localparam logic [W-1:0] V1 = 256'h1111_2222_3333;
  localparam logic [W-1:0] V2 = 256'h4444_5555_6666;
  localparam logic [W-1:0] R3 = 256'h48656c6c6f;
  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_ready, req_mode = 1'b0;
  logic [W-1:0] req_p = '0, req_q = '0, req_msg = '0;
  logic [W-1:0] core_p, core_q, core_msg_in, rsp_msg;
  logic [W-1:0] core_msg_out = '0;
  logic core_encrypt_decrypt, core_reset, core_reset1, core_finish = 1'b0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  int checks = 0, failures = 0;
  int k;
  logic seen;
  always #5 clk = ~clk;
  rsa_job_sequencer #(.WIDTH(W), .KEYGEN_WAIT(KW), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_p(req_p), .req_q(req_q), .req_msg(req_msg), .req_mode(req_mode),
    .core_p(core_p), .core_q(core_q), .core_msg_in(core_msg_in),
    .core_encrypt_decrypt(core_encrypt_decrypt), .core_reset(core_reset),
    .core_reset1(core_reset1), .core_msg_out(core_msg_out), .core_finish(core_finish),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_msg(rsp_msg), .rsp_timeout(rsp_timeout)
  );
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [W-1:0] p, input logic [W-1:0] q, input logic [W-1:0] m, input logic md);
    @(negedge clk);
    req_p = p; req_q = q; req_msg = m; req_mode = md; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic wait_r1(output int n);
    n = 0;
    while (!core_reset1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reset1_seen", W'(core_reset1), W'(1));
  endtask
  task automatic wait_rsp(input int bound, output int n);
    n = 0;
    while (!rsp_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_core_reset", W'({core_reset, core_reset1}), W'(0));
    chk("rst_core_p", core_p, '0);
    chk("rst_core_q", core_q, '0);
    chk("rst_core_msg_in", core_msg_in, '0);
    chk("rst_mode_timeout", W'({core_encrypt_decrypt, rsp_timeout}), W'(0));
    chk("rst_rsp_msg", rsp_msg, '0);
    // basic encrypt job with a core that finishes 300 cycles after reset1
    send(P, Q, M1, 1'b1);
    chk("acc_core_reset", W'(core_reset), W'(1));
    chk("acc_req_ready", W'(req_ready), W'(0));
    chk("acc_core_p", core_p, P);
    chk("acc_core_q", core_q, Q);
    chk("acc_core_msg", core_msg_in, M1);
    chk("acc_mode", W'(core_encrypt_decrypt), W'(1));
    @(negedge clk);
    chk("core_reset_len", W'(core_reset), W'(0));
    wait_r1(k);
    chk("reset1_delay", W'(k + 1), W'(KW + 1));
    @(negedge clk);
    chk("reset1_len", W'(core_reset1), W'(0));
    repeat (299) @(negedge clk);
    core_msg_out = R1;
    core_finish = 1'b1;
    wait_rsp(50, k);
    chk("job1_valid", W'(rsp_valid), W'(1));
    chk("job1_msg", rsp_msg, R1);
    chk("job1_timeout", W'(rsp_timeout), W'(0));
    for (int i = 0; i < 20; i++) begin
      req_valid = i[0];
      @(negedge clk);
      chk("hold_valid", W'(rsp_valid), W'(1));
      chk("hold_msg", rsp_msg, R1);
      chk("hold_req_ready", W'(req_ready), W'(0));
    end
    req_valid = 1'b0;
    chk("hold_core_p", core_p, P);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    core_finish = 1'b0;
    chk("job1_done_valid", W'(rsp_valid), W'(0));
    chk("job1_done_ready", W'(req_ready), W'(1));
    @(negedge clk);
    chk("idle_stays", W'(req_ready), W'(1));
    // finish already high before START must be ignored until it falls and rises
    core_msg_out = V1;
    core_finish = 1'b1;
    rsp_ready = 1'b1;
    send(M1, P, Q, 1'b1);
    wait_r1(k);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    chk("stale_finish", W'(seen), W'(0));
    core_finish = 1'b0;
    repeat (3) @(negedge clk);
    core_msg_out = V2;
    core_finish = 1'b1;
    wait_rsp(10, k);
    chk("rerise_valid", W'(rsp_valid), W'(1));
    chk("rerise_msg", rsp_msg, V2);
    @(negedge clk);
    chk("ready_early_valid", W'(rsp_valid), W'(0));
    chk("ready_early_req", W'(req_ready), W'(1));
    core_finish = 1'b0;
    rsp_ready = 1'b0;
    // core never finishes
    send(P, Q, M1, 1'b1);
    wait_r1(k);
`ifdef RSA_SEQ_TIMEOUT_EN
    wait_rsp(200, k);
    chk("timeout_delay", W'(k), W'(65));
    chk("timeout_flag", W'(rsp_timeout), W'(1));
    chk("timeout_msg", rsp_msg, '0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("timeout_done", W'(rsp_valid), W'(0));
`else
    seen = 1'b0;
    repeat (10000) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    chk("no_timeout_valid", W'(seen), W'(0));
    chk("no_timeout_flag", W'(rsp_timeout), W'(0));
`endif
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    // reset during KEYGEN aborts silently
    send(P, Q, M3, 1'b0);
    repeat (30) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_req_ready", W'(req_ready), W'(1));
    chk("abort_core_p", core_p, '0);
    chk("abort_core_msg", core_msg_in, '0);
    chk("abort_valid", W'(rsp_valid), W'(0));
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= rsp_valid | core_reset1;
    end
    chk("abort_quiet", W'(seen), W'(0));
    send(P, Q, M3, 1'b0);
    chk("dec_mode", W'(core_encrypt_decrypt), W'(0));
    chk("dec_msg_in", core_msg_in, M3);
    wait_r1(k);
    chk("reset1_delay2", W'(k), W'(KW + 1));
    repeat (299) @(negedge clk);
    core_msg_out = R3;
    core_finish = 1'b1;
    wait_rsp(50, k);
    chk("dec_valid", W'(rsp_valid), W'(1));
    chk("dec_msg", rsp_msg, R3);
    chk("dec_timeout", W'(rsp_timeout), W'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("dec_done", W'(rsp_valid), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rsa_job_sequencer.md
RSA_JOB_SEQUENCER -- requirements
Module: rsa_job_sequencer

Interface
REQ-001 Parameter WIDTH, default 256, operand and message width in bits.
REQ-002 Parameter KEYGEN_WAIT, default 100, cycles between the core reset pulse and the core reset1 pulse.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, maximum RUN cycles before abort (used only with RSA_SEQ_TIMEOUT_EN).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1; req_ready  out  1  job request handshake.
REQ-007 req_p, req_q  in  WIDTH  primes; req_msg  in  WIDTH  message; req_mode  in  1  (1 = encrypt, 0 = decrypt).
REQ-008 core_p, core_q, core_msg_in  out  WIDTH; core_encrypt_decrypt  out  1  registered job operands driven to the RSA control core.
REQ-009 core_reset, core_reset1  out  1  active-high pulses to the core (key setup start, exponentiation start).
REQ-010 core_msg_out  in  WIDTH; core_finish  in  1  core result and done level.
REQ-011 rsp_valid  out  1; rsp_ready  in  1; rsp_msg  out  WIDTH; rsp_timeout  out  1  result handshake.

Function
REQ-012 FSM states IDLE, RST, KEYGEN, START, RUN, RESP; exactly one state active.
REQ-013 IDLE: req_ready = 1; when req_valid && req_ready, latch req_p/req_q/req_msg/req_mode into core_* registers and go to RST.
REQ-014 req_ready SHALL be 0 in every state other than IDLE; requests are never queued.
REQ-015 RST: core_reset = 1 for exactly one cycle; then go to KEYGEN with wait counter cleared.
REQ-016 KEYGEN: count KEYGEN_WAIT cycles; on terminal count go to START.
REQ-017 START: core_reset1 = 1 for exactly one cycle; then go to RUN, clear the RUN counter, clear the finish-history bit.
REQ-018 RUN: done is detected only on a rising edge of core_finish (sampled 0 then 1 in consecutive RUN cycles); a core_finish already high on RUN entry is ignored until it falls and rises again.
REQ-019 On done: capture core_msg_out into rsp_msg, rsp_timeout = 0, go to RESP.
REQ-020 RESP: rsp_valid = 1 and rsp_msg/rsp_timeout held stable until rsp_valid && rsp_ready; then return to IDLE (req_ready = 1 the following cycle).
REQ-021 rsp_ready already high on RESP entry completes the handshake in that first RESP cycle.
REQ-022 core_* operand outputs SHALL hold the latched values from acceptance until the next accepted request.
REQ-023 Counters are unsigned, sized as clog2 of their limit plus 1, and saturate; they never wrap.

Reset
REQ-024 reset low SHALL asynchronously force IDLE; req_ready = 1 after release; rsp_valid, rsp_timeout, core_reset, core_reset1, core_encrypt_decrypt = 0; rsp_msg, core_p, core_q, core_msg_in = 0; counters = 0.
REQ-025 reset asserted mid-job SHALL abort the job with no response issued.

Configuration
REQ-026 Macro RSA_SEQ_TIMEOUT_EN defined: if RUN reaches TIMEOUT_CYCLES without a done, go to RESP with rsp_timeout = 1 and rsp_msg = 0.
REQ-027 Macro RSA_SEQ_TIMEOUT_EN undefined: RUN waits indefinitely; rsp_timeout is constant 0; no timeout counter is built.

Structure
REQ-028 Shared package rsa_pkg holds the FSM state enum, the default WIDTH constant, and the mode encodings ENCRYPT = 1, DECRYPT = 0.
REQ-029 One sub-module, rsa_seq_counter (loadable saturating counter with terminal flag), is instanced for both KEYGEN and RUN counting; there is no other hierarchy.

Verification
REQ-030 Reset release -> req_ready = 1, rsp_valid = 0, core_reset = core_reset1 = 0, all core_* operands 0.
REQ-031 Request p = 113680897410347, q = 7999808077935876437321, mode = 1, msg = 0x48656c6c6f20576f726c6421, with a core model raising finish 300 cycles after reset1 -> core_reset pulse 1 cycle, core_reset1 pulse exactly KEYGEN_WAIT + 1 cycles later, rsp_valid with rsp_msg = model output, rsp_timeout = 0.
REQ-032 rsp_ready held low 20 cycles in RESP -> rsp_valid and rsp_msg stable for all 20 cycles; req_valid pulses during that window are not accepted (req_ready = 0).
REQ-033 core_finish held high from before START -> no completion until the model drops and re-raises finish; captured value is the one present at the re-rise.
REQ-034 With RSA_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 64, core_finish never rises -> RESP after 64 RUN cycles, rsp_timeout = 1, rsp_msg = 0; without the macro -> no rsp_valid after 10000 cycles.
REQ-035 reset pulled low during KEYGEN -> immediate IDLE, no rsp_valid; a new request of mode = 0, msg = 0x262d806a3e18f03ab37b2857e7e149 then completes normally.
